// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned WB_SEL_W_DEF = 2;
  localparam int unsigned CNT_W_DEF    = 32;
  localparam logic [1:0]  WB_MEM_DEF   = 2'b01;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Multi-cycle execute tracking
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_WAIT = 2'b01,
    MC_HELD = 2'b10
  } mc_state_t;

  // Stage register controls, one bit per stall/flush line
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctl_t;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Datapath <-> hazard controller signal bundle.
interface hazard_ctrl_mc_if #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned WB_SEL_W = 2,
  parameter int unsigned CNT_W    = 32
);

  logic [ADDR_W-1:0]   rs1_D;
  logic [ADDR_W-1:0]   rs2_D;
  logic [ADDR_W-1:0]   rs1_E;
  logic [ADDR_W-1:0]   rs2_E;
  logic [ADDR_W-1:0]   rd_E;
  logic [ADDR_W-1:0]   rd_M;
  logic [ADDR_W-1:0]   rd_W;
  logic                reg_wr_M;
  logic                reg_wr_W;
  logic [WB_SEL_W-1:0] sel_wb_E;
  logic                br_en_E;
  logic                mc_start_E;
  logic                mc_done;
  logic                dmem_req_M;
  logic                dmem_ready_M;
  logic                perf_clr;

  logic                stallF;
  logic                stallD;
  logic                stallE;
  logic                stallM;
  logic                flushD;
  logic                flushE;
  logic                flushM;
  logic                flushW;
  logic [1:0]          forwardAE;
  logic [1:0]          forwardBE;
  logic [CNT_W-1:0]    perf_stall_cycles;
  logic [CNT_W-1:0]    perf_br_flushes;

  // Datapath side: supplies pipeline state, consumes controls
  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    output reg_wr_M, reg_wr_W, sel_wb_E, br_en_E,
    output mc_start_E, mc_done, dmem_req_M, dmem_ready_M, perf_clr,
    input  stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushM, flushW,
    input  forwardAE, forwardBE, perf_stall_cycles, perf_br_flushes
  );

  // Hazard controller side
  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    input  reg_wr_M, reg_wr_W, sel_wb_E, br_en_E,
    input  mc_start_E, mc_done, dmem_req_M, dmem_ready_M, perf_clr,
    output stallF, stallD, stallE, stallM,
    output flushD, flushE, flushM, flushW,
    output forwardAE, forwardBE, perf_stall_cycles, perf_br_flushes
  );

endinterface

// File: rtl/hazard_mc_fsm.sv
// Tracks an outstanding multi-cycle E-stage op and a result held behind a memory wait.
module hazard_mc_fsm
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mc_start,
  input  logic mc_done,
  input  logic memwait,
  output logic mc_stall
);

  mc_state_t state_q;
  mc_state_t state_d;

  // State register; reset drops any pending or held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Transitions; the stall is live in the start cycle and drops in the release cycle
  always_comb begin
    state_d  = state_q;
    mc_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mc_start && !mc_done) begin
          state_d  = MC_WAIT;
          mc_stall = 1'b1;
        end
      end
      MC_WAIT: begin
        mc_stall = !mc_done || memwait;
        if (mc_done) begin
          state_d = memwait ? MC_HELD : RUN;
        end
      end
      MC_HELD: begin
        mc_stall = memwait;
        if (!memwait) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: forwarding, stall/flush priority encoder, perf counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned         ADDR_W       = ADDR_W_DEF,
  parameter int unsigned         WB_SEL_W     = WB_SEL_W_DEF,
  parameter logic [WB_SEL_W-1:0] WB_MEM       = WB_SEL_W'(WB_MEM_DEF),
  parameter int unsigned         CNT_W        = CNT_W_DEF,
  parameter bit                  X0_HARDWIRED = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  hazard_ctrl_mc_if.slave hz
);

  logic             memwait;
  logic             mc_stall;
  logic             mcwait;
  logic             loaduse;
  logic             br_fire;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  hz_ctl_t          ctl;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] br_cnt_q;

  // Address equality with optional x0 exclusion
  function automatic logic reg_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a == b) && (!X0_HARDWIRED || (a != '0));
  endfunction

  hazard_mc_fsm u_mc_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .mc_start (hz.mc_start_E),
    .mc_done  (hz.mc_done),
    .memwait  (memwait),
    .mc_stall (mc_stall)
  );

  // Operand forwarding, M stage wins over W stage
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (hz.reg_wr_M && reg_match(hz.rd_M, hz.rs1_E)) begin
      fwd_a = FWD_M;
    end else if (hz.reg_wr_W && reg_match(hz.rd_W, hz.rs1_E)) begin
      fwd_a = FWD_W;
    end
    if (hz.reg_wr_M && reg_match(hz.rd_M, hz.rs2_E)) begin
      fwd_b = FWD_M;
    end else if (hz.reg_wr_W && reg_match(hz.rd_W, hz.rs2_E)) begin
      fwd_b = FWD_W;
    end
  end

  // Hazard causes; a branch waits in E until nothing ahead of it holds E
  always_comb begin
    memwait = hz.dmem_req_M && !hz.dmem_ready_M;
    mcwait  = mc_stall && !memwait;
    loaduse = (hz.sel_wb_E == WB_MEM) &&
              (reg_match(hz.rd_E, hz.rs1_D) || reg_match(hz.rd_E, hz.rs2_D));
    br_fire = rst_n && hz.br_en_E && !memwait && !mcwait;
  end

  // Priority encoder onto the stage register controls
  always_comb begin
    ctl = '0;
    if (rst_n) begin
      if (memwait) begin
        ctl.stall_f = 1'b1;
        ctl.stall_d = 1'b1;
        ctl.stall_e = 1'b1;
        ctl.stall_m = 1'b1;
        ctl.flush_w = 1'b1;
      end else if (mcwait) begin
        ctl.stall_f = 1'b1;
        ctl.stall_d = 1'b1;
        ctl.stall_e = 1'b1;
        ctl.flush_m = 1'b1;
      end else begin
        if (loaduse) begin
          ctl.stall_f = 1'b1;
          ctl.stall_d = 1'b1;
          ctl.flush_e = 1'b1;
        end
        if (br_fire) begin
          ctl.flush_d = 1'b1;
          ctl.flush_e = 1'b1;
        end
      end
    end
  end

  // Saturating performance counters, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else if (hz.perf_clr) begin
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      if (ctl.stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (br_fire && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.stallF            = ctl.stall_f;
  assign hz.stallD            = ctl.stall_d;
  assign hz.stallE            = ctl.stall_e;
  assign hz.stallM            = ctl.stall_m;
  assign hz.flushD            = ctl.flush_d;
  assign hz.flushE            = ctl.flush_e;
  assign hz.flushM            = ctl.flush_m;
  assign hz.flushW            = ctl.flush_w;
  assign hz.forwardAE         = rst_n ? fwd_a : FWD_RF;
  assign hz.forwardBE         = rst_n ? fwd_b : FWD_RF;
  assign hz.perf_stall_cycles = stall_cnt_q;
  assign hz.perf_br_flushes   = br_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: directed scenarios then random traffic.
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  localparam int unsigned AW      = 5;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam logic [1:0]  WBM     = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.ADDR_W(AW), .WB_SEL_W(2), .CNT_W(CW)) hif ();

  hazard_ctrl_mc #(
    .ADDR_W(AW), .WB_SEL_W(2), .WB_MEM(WBM), .CNT_W(CW), .X0_HARDWIRED(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       reg_wr_M, reg_wr_W;
    logic [1:0] sel_wb_E;
    logic       br_en_E, mc_start_E, mc_done, dmem_req_M, dmem_ready_M, perf_clr;
  } stim_t;

  typedef struct packed {
    logic [7:0] ctl;  // stallF stallD stallE stallM flushD flushE flushM flushW
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] psc;
    logic [3:0] pbf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: an op issued and not finished, or finished but stuck behind memory
  bit m_busy = 1'b0;
  bit m_held = 1'b0;
  int m_psc  = 0;
  int m_pbf  = 0;

  function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input stim_t s);
    if (s.reg_wr_M && same_reg(s.rd_M, rs)) return 2'b10;
    if (s.reg_wr_W && same_reg(s.rd_W, rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus, predict the outputs, advance the reference state
  task automatic step(input stim_t s);
    exp_t e;
    bit   mem, fresh, mcw, lu, br, sf;
    @(posedge clk);
    #1;
    rst_n            = s.rst_n;
    hif.rs1_D        = s.rs1_D;
    hif.rs2_D        = s.rs2_D;
    hif.rs1_E        = s.rs1_E;
    hif.rs2_E        = s.rs2_E;
    hif.rd_E         = s.rd_E;
    hif.rd_M         = s.rd_M;
    hif.rd_W         = s.rd_W;
    hif.reg_wr_M     = s.reg_wr_M;
    hif.reg_wr_W     = s.reg_wr_W;
    hif.sel_wb_E     = s.sel_wb_E;
    hif.br_en_E      = s.br_en_E;
    hif.mc_start_E   = s.mc_start_E;
    hif.mc_done      = s.mc_done;
    hif.dmem_req_M   = s.dmem_req_M;
    hif.dmem_ready_M = s.dmem_ready_M;
    hif.perf_clr     = s.perf_clr;
    if (!s.rst_n) begin
      m_busy = 1'b0;
      m_held = 1'b0;
      m_psc  = 0;
      m_pbf  = 0;
      e      = '0;
      exp_q.push_back(e);
      return;
    end
    mem   = s.dmem_req_M && !s.dmem_ready_M;
    fresh = !m_busy && !m_held && s.mc_start_E && !s.mc_done;
    mcw   = !mem && ((m_busy && !s.mc_done) || fresh);
    lu    = !mem && !mcw && (s.sel_wb_E == WBM) &&
            (same_reg(s.rd_E, s.rs1_D) || same_reg(s.rd_E, s.rs2_D));
    br    = s.br_en_E && !mem && !mcw;
    sf    = mem || mcw || lu;
    e.ctl = {sf, sf, mem || mcw, mem, br, lu || br, mcw, mem};
    e.fa  = fwd_of(s.rs1_E, s);
    e.fb  = fwd_of(s.rs2_E, s);
    e.psc = 4'(m_psc);
    e.pbf = 4'(m_pbf);
    exp_q.push_back(e);
    if (s.perf_clr) begin
      m_psc = 0;
      m_pbf = 0;
    end else begin
      if (sf && m_psc < CNT_MAX) m_psc++;
      if (br && m_pbf < CNT_MAX) m_pbf++;
    end
    if (fresh) begin
      m_busy = 1'b1;
    end else if (m_busy && s.mc_done) begin
      m_busy = 1'b0;
      m_held = mem;
    end else if (m_held && !mem) begin
      m_held = 1'b0;
    end
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctl", 32'({hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                        hif.flushD, hif.flushE, hif.flushM, hif.flushW}), 32'(e.ctl));
      check("fwd", 32'({hif.forwardAE, hif.forwardBE}), 32'({e.fa, e.fb}));
      check("perf", 32'({hif.perf_stall_cycles, hif.perf_br_flushes}), 32'({e.psc, e.pbf}));
    end
  end

  initial begin
    stim_t s;

    // reset state
    s = idle();
    s.rst_n = 1'b0;
    repeat (3) step(s);

    // forwarding priority and x0
    s = idle();
    s.rs1_E = 5'd5; s.rs2_E = 5'd5; s.rd_M = 5'd5; s.rd_W = 5'd5;
    s.reg_wr_M = 1'b1; s.reg_wr_W = 1'b1;
    step(s);
    s.rd_M = 5'd0;
    step(s);
    s.rs1_E = 5'd0; s.rd_W = 5'd0;
    step(s);

    // load-use bubble
    s = idle();
    s.sel_wb_E = WBM; s.rd_E = 5'd7; s.rs2_D = 5'd7;
    step(s);
    s = idle();
    repeat (2) step(s);

    // multi-cycle op, done after 4 stall cycles
    s = idle();
    s.mc_start_E = 1'b1;
    repeat (4) step(s);
    s.mc_done = 1'b1;
    step(s);
    s = idle();
    step(s);

    // mc_done lands inside a memory wait
    s = idle();
    s.mc_start_E = 1'b1;
    repeat (2) step(s);
    s.dmem_req_M = 1'b1; s.mc_done = 1'b1;
    step(s);
    s.mc_done = 1'b0;
    repeat (2) step(s);
    s.dmem_ready_M = 1'b1;
    step(s);
    s = idle();
    step(s);

    // branch deferred by a memory wait
    s = idle();
    s.br_en_E = 1'b1; s.dmem_req_M = 1'b1;
    repeat (2) step(s);
    s.dmem_req_M = 1'b0;
    step(s);
    s = idle();
    step(s);

    // counter saturation and clear
    s = idle(); s.perf_clr = 1'b1; step(s);
    s = idle(); s.dmem_req_M = 1'b1;
    repeat (20) step(s);
    s = idle(); step(s);
    s.perf_clr = 1'b1; step(s);
    s = idle(); step(s);

    // async reset in the middle of a multi-cycle wait
    s = idle();
    s.mc_start_E = 1'b1;
    repeat (2) step(s);
    s.rst_n = 1'b0;
    step(s);
    s = idle();
    repeat (2) step(s);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst_n        = 1'($urandom_range(0, 149) != 0);
      s.rs1_D        = 5'($urandom_range(0, 3));
      s.rs2_D        = 5'($urandom_range(0, 3));
      s.rs1_E        = 5'($urandom_range(0, 3));
      s.rs2_E        = 5'($urandom_range(0, 3));
      s.rd_E         = 5'($urandom_range(0, 3));
      s.rd_M         = 5'($urandom_range(0, 3));
      s.rd_W         = 5'($urandom_range(0, 3));
      s.reg_wr_M     = 1'($urandom_range(0, 1));
      s.reg_wr_W     = 1'($urandom_range(0, 1));
      s.sel_wb_E     = 2'($urandom_range(0, 3));
      s.br_en_E      = 1'((s.sel_wb_E != WBM) && ($urandom_range(0, 3) == 0));
      s.mc_start_E   = (m_busy || m_held) ? 1'b1 : 1'($urandom_range(0, 4) == 0);
      s.mc_done      = 1'($urandom_range(0, 3) == 0);
      s.dmem_req_M   = 1'($urandom_range(0, 1));
      s.dmem_ready_M = 1'($urandom_range(0, 1));
      s.perf_clr     = 1'($urandom_range(0, 29) == 0);
      step(s);
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Next-generation pipeline hazard controller for the 5-stage RV32 core (F/D/E/M/W).
- Adds to plain forwarding, load-use and branch handling: a variable-latency data-memory wait, a multi-cycle execute unit (MUL/DIV) handshake with a held-result state, explicit stall/flush for every stage, and saturating performance counters.
- Sits beside the datapath and drives the stage register enables/clears and the E-stage operand forwarding muxes.

Parameters:
ADDR_W, 5, register address width
WB_SEL_W, 2, width of the writeback-select field
WB_MEM, 2'b01, sel_wb code meaning "result comes from data memory" (load)
CNT_W, 32, performance counter width
X0_HARDWIRED, 1, 1 = register 0 never matches for forwarding or hazards

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_D, rs2_D  in  ADDR_W  D-stage source registers
rs1_E, rs2_E, rd_E  in  ADDR_W  E-stage source/destination registers
rd_M, rd_W  in  ADDR_W  M/W destination registers
reg_wr_M, reg_wr_W  in  1  M/W write enables
sel_wb_E  in  WB_SEL_W  E-stage writeback select
br_en_E  in  1  branch/jump taken, resolved in E
mc_start_E  in  1  E holds a multi-cycle op; high for as long as it stays in E
mc_done  in  1  one-cycle pulse: the multi-cycle result is valid
dmem_req_M  in  1  M-stage memory access in progress
dmem_ready_M  in  1  memory completes the access this cycle
perf_clr  in  1  synchronous counter clear
stallF, stallD, stallE, stallM  out  1  hold the stage register
flushD, flushE, flushM, flushW  out  1  insert a bubble into the stage register
forwardAE, forwardBE  out  2  00 = regfile, 10 = from M, 01 = from W, 11 unused
perf_stall_cycles  out  CNT_W  cycles with stallF = 1
perf_br_flushes  out  CNT_W  taken-branch flush events

Behaviour:
Reset
- While rst_n = 0: all stall/flush outputs 0, forward codes 00, both counters 0, FSM in RUN.

Match rule
- A register "matches" when the addresses are equal and, if X0_HARDWIRED = 1, the address is non-zero.

Forwarding (combinational)
- forwardAE = 10 if reg_wr_M and rd_M matches rs1_E.
- Otherwise forwardAE = 01 if reg_wr_W and rd_W matches rs1_E.
- Otherwise forwardAE = 00. forwardBE is identical, using rs2_E.
- M has priority over W.

Stall causes, highest priority first
- memwait = dmem_req_M & !dmem_ready_M
  - Outputs: stallF, stallD, stallE, stallM = 1; flushW = 1.
  - Branch and load-use actions are suppressed.
- mcwait = FSM in MC_WAIT or MC_HELD (without memwait)
  - Outputs: stallF, stallD, stallE = 1; flushM = 1.
- loaduse = sel_wb_E == WB_MEM and rd_E matches rs1_D or rs2_D (without the two above)
  - Outputs: stallF, stallD = 1; flushE = 1.
- branch = br_en_E and E not stalled
  - Outputs: flushD = 1, flushE = 1.
  - A branch seen while memwait is active is acted on in the first cycle memwait clears.
  - Branch and loaduse never coincide, since a load in E is not a branch.

FSM (state registered; outputs decoded from state and inputs)
- RUN
  - mc_start_E & !mc_done: go to MC_WAIT; the stall applies in the same cycle (mcwait is also asserted combinationally when RUN & mc_start_E & !mc_done).
  - mc_start_E & mc_done: no stall; stay in RUN.
- MC_WAIT
  - mc_done & !memwait: go to RUN; stalls release in that cycle, so the instruction advances on that edge.
  - mc_done & memwait: go to MC_HELD.
- MC_HELD
  - Result is held; stallE stays 1.
  - Go to RUN in the first cycle with !memwait; the stall releases in that cycle.
- mc_done while in RUN with !mc_start_E: ignored.

Counters
- perf_stall_cycles increments every cycle stallF = 1.
- perf_br_flushes increments every cycle the branch action fires.
- Both saturate at all-ones.
- perf_clr takes priority over increment and clears both to 0 at the next edge.

Async reset mid-operation
- Aborts any wait. The FSM returns to RUN and no held result survives.

Decomposition:
- hazard_pkg:
  - fwd_sel_t enum (FWD_RF = 00, FWD_W = 01, FWD_M = 10)
  - mc_state_t enum (RUN, MC_WAIT, MC_HELD)
  - default WB_MEM constant
- One sub-module, hazard_mc_fsm:
  - Owns the state register and transitions.
  - Outputs mc_stall.
- The top level owns forwarding, the priority encoder and the counters.

Test Plan:
- Forwarding: rs1_E = 5, rd_M = 5, reg_wr_M = 1, rd_W = 5, reg_wr_W = 1 -> forwardAE = 10. Then rd_M = 0 -> forwardAE = 01. Then rs1_E = 0 with X0_HARDWIRED = 1 -> 00.
- Load-use: sel_wb_E = 01, rd_E = 7, rs2_D = 7 -> stallF = stallD = flushE = 1 for exactly 1 cycle; perf_stall_cycles = 1.
- Multi-cycle op: mc_start_E held, mc_done after 4 cycles -> stallF/D/E and flushM high for 4 cycles, low in the mc_done cycle; FSM back in RUN.
- mc_done during memwait: dmem_ready_M low for 3 cycles overlapping mc_done -> MC_HELD entered; stallE stays 1 until dmem_ready_M = 1, then all stalls drop in the same cycle.
- Branch deferred by memwait: br_en_E = 1 with memwait active for 2 cycles -> no flushD/flushE during memwait; flushD = flushE = 1 in the first free cycle; perf_br_flushes = 1.
- Saturation and reset:
  - CNT_W = 4: hold a stall for 20 cycles -> perf_stall_cycles = 15.
  - perf_clr -> 0.
  - rst_n low mid-MC_WAIT -> all outputs 0 immediately; FSM in RUN after release.
